// File: rtl/riscv_dmem_pkg.sv
// Shared types and helpers for the tightly-coupled data memory.
package riscv_dmem_pkg;

  localparam int TAG_W = 11;

  typedef struct packed {
    logic             valid;
    logic             error;
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } resp_t;

  // Widened to 34 bits so a window that ends at the top of the address space cannot wrap.
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input int unsigned size_words);
    logic [33:0] off;
    logic [33:0] span;
    off  = {2'b00, addr} - {2'b00, base};
    span = 34'(size_words) << 2;
    return (addr >= base) && (off < span);
  endfunction

endpackage

// File: rtl/riscv_dmem_resp_pipe.sv
// Fixed-depth response delay line; the head stage drives the registered response outputs.
module riscv_dmem_resp_pipe
  import riscv_dmem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  resp_t load,
  output resp_t head
);

  resp_t stage_q [LATENCY];

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= load;
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign head = stage_q[LATENCY-1];

endmodule

// File: rtl/riscv_dmem_tcm.sv
// Tightly-coupled data memory: byte-strobed word RAM with fixed-latency, in-order tagged responses.
module riscv_dmem_tcm
  import riscv_dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int          SIZE_WORDS      = 1024,
  parameter int          LATENCY         = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_d_addr_i,
  input  logic [31:0]      mem_d_data_wr_i,
  input  logic             mem_d_rd_i,
  input  logic [3:0]       mem_d_wr_i,
  input  logic             mem_d_cacheable_i,
  input  logic [TAG_W-1:0] mem_d_req_tag_i,
  input  logic             mem_d_invalidate_i,
  input  logic             mem_d_writeback_i,
  input  logic             mem_d_flush_i,
  output logic             mem_d_accept_o,
  output logic             mem_d_ack_o,
  output logic             mem_d_error_o,
  output logic [TAG_W-1:0] mem_d_resp_tag_o,
  output logic [31:0]      mem_d_data_rd_o
);

  localparam int IDX_W = $clog2(SIZE_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]      ram [SIZE_WORDS];
  logic [CNT_W-1:0] count;
  logic [2:0]       maint;
  logic [31:0]      offset;
  logic [IDX_W-1:0] word_idx;
  logic             access;
  logic             present;
  logic             accept;
  logic             fire;
  logic             bad;
  resp_t            load;
  resp_t            head;
  logic             unused_ok;

  assign maint    = {mem_d_invalidate_i, mem_d_writeback_i, mem_d_flush_i};
  assign access   = mem_d_rd_i || (|mem_d_wr_i);
  assign present  = access || (|maint);
  assign offset   = mem_d_addr_i - BASE_ADDR;
  assign word_idx = offset[IDX_W+1:2];

  // An ack leaving this cycle frees a slot, so a full tracker can still accept.
  assign accept = !rst_i && ((count < CNT_W'(MAX_OUTSTANDING)) || head.valid);
  assign fire   = present && accept;

  assign bad = (mem_d_addr_i[1:0] != 2'b00)
            || (mem_d_rd_i && (|mem_d_wr_i))
            || ((maint & (maint - 3'd1)) != 3'd0)
            || ((|maint) && access)
            || (access && !in_window(mem_d_addr_i, BASE_ADDR, 32'(SIZE_WORDS)));

  // Read data is captured at accept, so later writes cannot disturb an in-flight response.
  assign load.valid = fire;
  assign load.error = fire && bad;
  assign load.tag   = fire ? mem_d_req_tag_i : '0;
  assign load.data  = (fire && mem_d_rd_i && !bad) ? ram[word_idx] : 32'h0;

  // NOTE: the RAM has no reset branch; clearing an array costs a mux per bit and contents survive reset.
  always_ff @(posedge clk_i) begin
    if (fire && !bad && (|mem_d_wr_i)) begin
      for (int k = 0; k < 4; k++) begin
        if (mem_d_wr_i[k]) ram[word_idx][8*k +: 8] <= mem_d_data_wr_i[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else begin
      case ({fire, head.valid})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  riscv_dmem_resp_pipe #(.LATENCY(LATENCY)) u_resp_pipe (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (load),
    .head  (head)
  );

  assign mem_d_accept_o   = accept;
  assign mem_d_ack_o      = head.valid;
  assign mem_d_error_o    = head.error;
  assign mem_d_resp_tag_o = head.tag;
  assign mem_d_data_rd_o  = head.data;

  assign unused_ok = ^{mem_d_cacheable_i, offset[1:0], offset[31:IDX_W+2]};

endmodule

// File: tb/tb_riscv_dmem_tcm.sv
// Self-checking bench: vector table plus scoreboard for the data TCM, with a throttled second instance.
module tb_riscv_dmem_tcm;
  import riscv_dmem_pkg::*;

  localparam int LAT = 2;

  typedef struct {
    logic             rd;
    logic [3:0]       wr;
    logic [2:0]       maint;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             exp_err;
    logic [31:0]      exp_data;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             err;
    logic [31:0]      data;
    int               due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             rd;
  logic [3:0]       wr;
  logic [TAG_W-1:0] tag;
  logic             inv;
  logic             wb;
  logic             fl;
  logic             accept;
  logic             ack;
  logic             err;
  logic [TAG_W-1:0] rtag;
  logic [31:0]      rdata;

  logic             d1_rd;
  logic             d1_accept;
  logic             d1_ack;
  logic             d1_err;
  logic [TAG_W-1:0] d1_tag;
  logic [31:0]      d1_data;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;
  int   ncyc     = 0;

  riscv_dmem_tcm #(.LATENCY(LAT), .MAX_OUTSTANDING(2)) u_dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .mem_d_addr_i       (addr),
    .mem_d_data_wr_i    (wdata),
    .mem_d_rd_i         (rd),
    .mem_d_wr_i         (wr),
    .mem_d_cacheable_i  (1'b1),
    .mem_d_req_tag_i    (tag),
    .mem_d_invalidate_i (inv),
    .mem_d_writeback_i  (wb),
    .mem_d_flush_i      (fl),
    .mem_d_accept_o     (accept),
    .mem_d_ack_o        (ack),
    .mem_d_error_o      (err),
    .mem_d_resp_tag_o   (rtag),
    .mem_d_data_rd_o    (rdata)
  );

  riscv_dmem_tcm #(.LATENCY(LAT), .MAX_OUTSTANDING(1)) u_dut1 (
    .clk_i              (clk),
    .rst_i              (rst),
    .mem_d_addr_i       (32'h8000_0004),
    .mem_d_data_wr_i    (32'h0),
    .mem_d_rd_i         (d1_rd),
    .mem_d_wr_i         (4'b0000),
    .mem_d_cacheable_i  (1'b0),
    .mem_d_req_tag_i    (11'h7),
    .mem_d_invalidate_i (1'b0),
    .mem_d_writeback_i  (1'b0),
    .mem_d_flush_i      (1'b0),
    .mem_d_accept_o     (d1_accept),
    .mem_d_ack_o        (d1_ack),
    .mem_d_error_o      (d1_err),
    .mem_d_resp_tag_o   (d1_tag),
    .mem_d_data_rd_o    (d1_data)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd_v, input logic [3:0] wr_v, input logic [2:0] m_v,
                              input logic [31:0] a_v, input logic [31:0] d_v,
                              input logic [TAG_W-1:0] t_v, input logic e_v, input logic [31:0] x_v);
    vec_t v;
    v.rd = rd_v; v.wr = wr_v; v.maint = m_v; v.addr = a_v; v.data = d_v;
    v.tag = t_v; v.exp_err = e_v; v.exp_data = x_v;
    return v;
  endfunction

  task automatic idle();
    @(negedge clk);
    rd = 1'b0; wr = 4'b0; {inv, wb, fl} = 3'b000; addr = '0; wdata = '0; tag = '0;
  endtask

  // Drives one request, holds it until accepted and pushes the expected response.
  task automatic issue(input vec_t v, output int waits);
    logic acc;
    @(negedge clk);
    rd = v.rd; wr = v.wr; {inv, wb, fl} = v.maint; addr = v.addr; wdata = v.data; tag = v.tag;
    waits = 0;
    forever begin
      #1;
      acc = accept;
      @(posedge clk);
      if (acc) break;
      waits++;
      if (waits > 20) break;
      @(negedge clk);
    end
    if (waits > 20) begin
      check("accept_timeout", 64'(waits), 64'd0);
    end else begin
      sb.push_back('{tag: v.tag, err: v.exp_err, data: v.exp_data, due: ncyc + LAT});
    end
  endtask

  task automatic drain();
    repeat (LAT + 2) @(negedge clk);
    check("drain_queue_empty", 64'(sb.size()), 64'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (ack) begin
        check("ack_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ack_tag",     64'(rtag),  64'(e.tag));
          check("ack_error",   64'(err),   64'(e.err));
          check("ack_data",    64'(rdata), 64'(e.data));
          check("ack_latency", 64'(ncyc),  64'(e.due));
        end
      end else begin
        check("idle_outputs_zero", {31'b0, err, rdata}, 64'd0);
        if (sb.size() != 0 && sb[0].due <= ncyc) begin
          check("ack_missing", 64'(ack), 64'd1);
          void'(sb.pop_front());
        end
      end
    end
  endtask

  initial begin
    int w;

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    rst = 1'b1; d1_rd = 1'b0;
    rd = 1'b0; wr = 4'b0; {inv, wb, fl} = 3'b000; addr = '0; wdata = '0; tag = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_accept",    64'(accept),    64'd0);
    check("reset_ack",       64'(ack),       64'd0);
    check("reset_resp_tag",  64'(rtag),      64'd0);
    check("reset_data",      64'(rdata),     64'd0);
    check("reset_d1_accept", 64'(d1_accept), 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset_accept", 64'(accept), 64'd1);

    vecs.push_back(mk(1'b0, 4'b1111, 3'b000, 32'h8000_0004, 32'hA5A5_A5A5, 11'h011, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0004, 32'h0,         11'h012, 1'b0, 32'hA5A5_A5A5));
    vecs.push_back(mk(1'b0, 4'b0010, 3'b000, 32'h8000_0004, 32'h0000_3C00, 11'h013, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0004, 32'h0,         11'h014, 1'b0, 32'hA5A5_3CA5));
    vecs.push_back(mk(1'b0, 4'b1111, 3'b000, 32'h7000_0000, 32'h5A5A_5A5A, 11'h020, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0004, 32'h0,         11'h021, 1'b0, 32'hA5A5_3CA5));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0006, 32'h0,         11'h022, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 4'b1111, 3'b000, 32'h8000_0008, 32'h1122_3344, 11'h023, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 4'b1111, 3'b000, 32'h8000_0008, 32'hFFFF_FFFF, 11'h024, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0008, 32'h0,         11'h025, 1'b0, 32'h1122_3344));
    vecs.push_back(mk(1'b0, 4'b1111, 3'b000, 32'h8000_0008, 32'h9999_9999, 11'h026, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0008, 32'h0,         11'h027, 1'b0, 32'h9999_9999));
    vecs.push_back(mk(1'b0, 4'b0000, 3'b100, 32'h8000_0000, 32'h0,         11'h030, 1'b0, 32'h0));
    vecs.push_back(mk(1'b0, 4'b0000, 3'b011, 32'h8000_0000, 32'h0,         11'h031, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b001, 32'h8000_0004, 32'h0,         11'h032, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 4'b1111, 3'b000, 32'h8000_0FFC, 32'hDEAD_BEEF, 11'h040, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0FFC, 32'h0,         11'h041, 1'b0, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_1000, 32'h0,         11'h042, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h7FFF_FFFC, 32'h0,         11'h043, 1'b1, 32'h0));
    vecs.push_back(mk(1'b0, 4'b1001, 3'b000, 32'h8000_0FFC, 32'hAA00_00BB, 11'h044, 1'b0, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0FFC, 32'h0,         11'h045, 1'b0, 32'hAAAD_BEBB));
    vecs.push_back(mk(1'b0, 4'b1111, 3'b000, 32'h8000_000A, 32'h0,         11'h046, 1'b1, 32'h0));
    vecs.push_back(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0008, 32'h0,         11'h047, 1'b0, 32'h9999_9999));

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i], w);
    idle();
    drain();

    // Four back-to-back reads must never stall with MAX_OUTSTANDING equal to LATENCY.
    for (int i = 1; i <= 4; i++) begin
      issue(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0004, 32'h0, TAG_W'(i), 1'b0, 32'hA5A5_3CA5), w);
      check("b2b_accept_stall", 64'(w), 64'd0);
    end
    idle();
    drain();

    // MAX_OUTSTANDING=1 instance with a held read: accepts on alternate cycles.
    @(negedge clk);
    d1_rd = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("throttle_accept", 64'(d1_accept), 64'((i % 2) == 0));
      @(negedge clk);
    end
    d1_rd = 1'b0;

    // Reset between accept and ack discards the response but keeps the write.
    issue(mk(1'b0, 4'b1111, 3'b000, 32'h8000_0020, 32'hCAFE_F00D, 11'h050, 1'b0, 32'h0), w);
    @(negedge clk);
    rst = 1'b1;
    rd = 1'b0; wr = 4'b0; {inv, wb, fl} = 3'b000;
    sb.delete();
    @(negedge clk);
    #1;
    check("midflight_reset_accept", 64'(accept),      64'd0);
    check("midflight_reset_count",  64'(u_dut.count), 64'd0);
    check("midflight_reset_ack",    64'(ack),         64'd0);
    rst = 1'b0;
    #1;
    check("midflight_release_accept", 64'(accept), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("no_ack_after_reset", 64'(ack), 64'd0);
    end
    issue(mk(1'b1, 4'b0000, 3'b000, 32'h8000_0020, 32'h0, 11'h051, 1'b0, 32'hCAFE_F00D), w);
    idle();
    drain();

    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_tcm.md
# riscv_dmem_tcm

Tightly-coupled data memory slave that sits directly downstream of `riscv_core`'s data port. It consumes the core's `mem_d_*` request outputs and produces `mem_d_accept_i`, `mem_d_ack_i`, `mem_d_error_i`, `mem_d_resp_tag_i` and `mem_d_data_rd_i`. It provides byte-strobed word storage over a fixed address window, fixed-latency in-order responses, outstanding-request throttling, and error responses for illegal or out-of-window accesses.

## Interface
Parameters:
- `BASE_ADDR`, 32'h80000000, first byte address of the window.
- `SIZE_WORDS`, 1024, number of 32-bit words; must be a power of 2.
- `LATENCY`, 2, cycles from accept to ack; legal range 1..8.
- `MAX_OUTSTANDING`, 2, maximum accepted-but-unacked requests; must be ≥1.

Ports:
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `mem_d_addr_i` in 32: byte address.
- `mem_d_data_wr_i` in 32: write data.
- `mem_d_rd_i` in 1: read request.
- `mem_d_wr_i` in 4: byte write strobes.
- `mem_d_cacheable_i` in 1: ignored; no functional effect.
- `mem_d_req_tag_i` in 11: request tag.
- `mem_d_invalidate_i`, `mem_d_writeback_i`, `mem_d_flush_i` in 1 each: maintenance ops.
- `mem_d_accept_o` out 1: request taken this cycle.
- `mem_d_ack_o` out 1: response valid (one-cycle pulse).
- `mem_d_error_o` out 1: response is an error.
- `mem_d_resp_tag_o` out 11: tag of the response.
- `mem_d_data_rd_o` out 32: read data.

## Operation
- **Request present:** `rd | (|wr) | invalidate | writeback | flush`. A request is accepted on any edge where it is present and `mem_d_accept_o`=1.
- **Accept rule:** `mem_d_accept_o = !rst_i && (count < MAX_OUTSTANDING || mem_d_ack_o)`.
- **count:** a register counting outstanding requests.
  - +1 on accept, −1 on ack; both in the same cycle leaves it unchanged.
  - Never exceeds `MAX_OUTSTANDING`.
- **Decode:** a request is in-window if `BASE_ADDR ≤ addr ≤ BASE_ADDR+4*SIZE_WORDS−1`. Word index is `(addr−BASE_ADDR)>>2`.
- **Error cases:** any of the following gives an error response with no RAM write:
  - out-of-window read or write;
  - `addr[1:0]≠0`;
  - `rd` together with a nonzero `wr`;
  - more than one maintenance op asserted;
  - a maintenance op together with `rd` or `wr`.
- **Write:** on the accept edge, byte k is written when `wr[k]=1`, using `data[8k+7:8k]`. The ack carries error=0 and data=0.
- **Read:** the RAM is read on the accept edge. Data is carried in the response pipeline, so a later write cannot alter an in-flight read response. A read accepted one cycle after a write to the same word returns the new data.
- **Maintenance ops:** no RAM effect; the ack carries error=0 and data=0.
- **Responses:** strictly in accept order. Each carries the request's tag. `mem_d_data_rd_o` is nonzero only for a non-error read ack.
- **No ack backpressure:** the core must take every ack.
- **`mem_d_cacheable_i`:** ignored.

## Timing
- **Reset:** while `rst_i`=1 at an edge, the following are cleared:
  - `ack_o`=0, `error_o`=0, `resp_tag_o`=0, `data_rd_o`=0;
  - `count`=0;
  - all pipeline valids.
- **During reset:** `accept_o`=0. RAM contents are not reset.
- **Latency:** a request accepted at edge T produces `ack_o`=1 during the cycle after edge T+LATENCY−1, i.e. exactly LATENCY cycles later. All response outputs are registered.
- **Throughput:** one request per cycle when `MAX_OUTSTANDING ≥ LATENCY`. Otherwise the sustained rate is MAX_OUTSTANDING per LATENCY cycles.
- **Reset mid-flight:**
  - writes already accepted remain committed;
  - in-flight responses are discarded and never acked;
  - `accept_o` returns to 1 in the first cycle with `rst_i`=0.
- **Held request:** a request present while `accept_o`=0 is not taken. The core holds it; no state changes.

## Structure
- **Package `riscv_dmem_pkg`:**
  - `TAG_W`=11;
  - response struct {valid, error, tag, data};
  - function `in_window(addr, base, size_words)`.
- **Sub-module `riscv_dmem_resp_pipe`:** LATENCY-deep shift register of the response struct, with synchronous clear.
- **RAM:** inferred array in the top module with per-byte write enables.

## Test plan
- **In-window write:** write 0xA5A5A5A5 to 0x80000004, tag 0x011, strobes 4'b1111 → ack 2 cycles later with tag 0x011, error 0. Read of the same address, tag 0x012 → data 0xA5A5A5A5.
- **Byte strobe:** after the above, write 0x00003C00 with strobes 4'b0010 → read returns 0xA5A53CA5.
- **Out-of-window write:** write 0x5A5A5A5A to 0x70000000, tag 0x020 → ack with error 1, data 0. A later read of 0x80000004 is unchanged.
- **Misaligned and combined ops:** read 0x80000006 → error 1. Same-cycle `rd`=1 with `wr`=4'b1111 at 0x80000008 → error 1, word unchanged.
- **Back-to-back, default parameters:** 4 reads on consecutive cycles (LATENCY=2, MAX=2), tags 1..4 → `accept_o` stays 1; acks on 4 consecutive cycles, tags 1,2,3,4 in order.
- **Throttling and reset:** with MAX=1, continuous requests → accept every 2nd cycle. Accept a write, then assert `rst_i` for 1 cycle before its ack → no ack ever; `count`=0; the written data reads back.
